// File: rtl/fft_pkg.sv
// Shared FFT definitions: frame geometry, sample type and index helpers.
package fft_pkg;

  localparam int FFT_POINTS = 8;
  localparam int FFT_LOG2   = 3;
  localparam int PAIRS      = 4;
  localparam int SAMPLE_W   = 16;

  // One packed complex sample: upper half real, lower half imaginary.
  typedef logic [SAMPLE_W-1:0] sample_t;

  // Reverse a 3-bit index (also used for twiddle indexing in later stages).
  function automatic logic [FFT_LOG2-1:0] bitrev3(input logic [FFT_LOG2-1:0] idx);
    return {idx[0], idx[1], idx[2]};
  endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One 8-entry frame buffer: single write port, two combinational read ports,
// asynchronous active-low clear of every word.
module fft_frame_bank
  import fft_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [FFT_LOG2-1:0] wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [FFT_LOG2-1:0] rd_addr_1,
  output logic [DATA_W-1:0]   rd_data_1,
  input  logic [FFT_LOG2-1:0] rd_addr_2,
  output logic [DATA_W-1:0]   rd_data_2
);

  logic [DATA_W-1:0] mem [FFT_POINTS];

  // Storage: cleared on reset, one word written per accepted sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FFT_POINTS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Both read ports are plain combinational lookups.
  always_comb begin
    rd_data_1 = mem[rd_addr_1];
    rd_data_2 = mem[rd_addr_2];
  end

endmodule

// File: rtl/fft_input_reorder.sv
// FFT front end: collects 8 natural-order samples into a ping-pong bank and
// drains each full frame as 4 bit-reversed operand pairs.
// Handshake: a transfer happens on a rising edge where valid && ready; valid
// never depends on ready, and data/valid hold steady until the transfer.
module fft_input_reorder
  import fft_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_1,
  output logic [DATA_W-1:0] out_2,
  output logic [1:0]        out_pair,
  output logic              out_last
);

  localparam logic [FFT_LOG2-1:0] LAST_WR = FFT_LOG2'(FFT_POINTS - 1);
  localparam logic [1:0]          LAST_RD = 2'(PAIRS - 1);

  logic                wr_bank;
  logic                rd_bank;
  logic [FFT_LOG2-1:0] wr_cnt;
  logic [1:0]          rd_cnt;
  logic [1:0]          bank_full;
  logic [1:0]          bank_full_nxt;

  logic                wr_fire;
  logic                rd_fire;
  logic [FFT_LOG2-1:0] rd_addr_1;
  logic [FFT_LOG2-1:0] rd_addr_2;
  logic [DATA_W-1:0]   b0_data_1;
  logic [DATA_W-1:0]   b0_data_2;
  logic [DATA_W-1:0]   b1_data_1;
  logic [DATA_W-1:0]   b1_data_2;

  // Handshake qualifiers and bit-reversed read addresses for pair k.
  always_comb begin
    in_ready  = !bank_full[wr_bank];
    out_valid = bank_full[rd_bank];
    wr_fire   = in_valid && in_ready;
    rd_fire   = out_valid && out_ready;
    rd_addr_1 = bitrev3({rd_cnt, 1'b0});
    rd_addr_2 = bitrev3({rd_cnt, 1'b1});
  end

  fft_frame_bank #(.DATA_W(DATA_W)) u_bank0 (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_fire && !wr_bank),
    .wr_addr   (wr_cnt),
    .wr_data   (in_data),
    .rd_addr_1 (rd_addr_1),
    .rd_data_1 (b0_data_1),
    .rd_addr_2 (rd_addr_2),
    .rd_data_2 (b0_data_2)
  );

  fft_frame_bank #(.DATA_W(DATA_W)) u_bank1 (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_fire && wr_bank),
    .wr_addr   (wr_cnt),
    .wr_data   (in_data),
    .rd_addr_1 (rd_addr_1),
    .rd_data_1 (b1_data_1),
    .rd_addr_2 (rd_addr_2),
    .rd_data_2 (b1_data_2)
  );

  // Output pair comes from whichever bank the read side is draining.
  always_comb begin
    out_1    = rd_bank ? b1_data_1 : b0_data_1;
    out_2    = rd_bank ? b1_data_2 : b0_data_2;
    out_pair = rd_cnt;
    out_last = out_valid && (rd_cnt == LAST_RD);
  end

  // Full flags: write side sets, read side clears; they always hit different banks.
  always_comb begin
    bank_full_nxt = bank_full;
    if (wr_fire && (wr_cnt == LAST_WR)) begin
      bank_full_nxt[wr_bank] = 1'b1;
    end
    if (rd_fire && (rd_cnt == LAST_RD)) begin
      bank_full_nxt[rd_bank] = 1'b0;
    end
  end

  // Write pointer and sample counter advance only on accepted samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_bank <= 1'b0;
      wr_cnt  <= '0;
    end else if (wr_fire) begin
      if (wr_cnt == LAST_WR) begin
        wr_cnt  <= '0;
        wr_bank <= !wr_bank;
      end else begin
        wr_cnt <= wr_cnt + 1'b1;
      end
    end
  end

  // Read pointer and pair counter advance only on consumed pairs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_bank <= 1'b0;
      rd_cnt  <= '0;
    end else if (rd_fire) begin
      if (rd_cnt == LAST_RD) begin
        rd_cnt  <= '0;
        rd_bank <= !rd_bank;
      end else begin
        rd_cnt <= rd_cnt + 1'b1;
      end
    end
  end

  // Full-flag register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_full <= 2'b00;
    end else begin
      bank_full <= bank_full_nxt;
    end
  end

endmodule

// File: tb/tb_fft_input_reorder.sv
// Bench for fft_input_reorder: frame-level reference model plus directed
// scenarios with hand-computed pair values.
module tb_fft_input_reorder;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_1;
  logic [W-1:0] out_2;
  logic [1:0]   out_pair;
  logic         out_last;

  int checks;
  int errors;

  fft_input_reorder #(.DATA_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_1     (out_1),
    .out_2     (out_2),
    .out_pair  (out_pair),
    .out_last  (out_last)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- comparison helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Frames are whole groups of 8 accepted samples; pair k of a frame is
  // (x[a], x[a+4]) with a taken from the bit-reversed order 0,2,1,3.
  logic [W-1:0] partial_q[$];
  logic [W-1:0] exp_q[$];
  int           rd_k;
  int           first_idx [4] = '{0, 2, 1, 3};

  function automatic int frames_held();
    return exp_q.size() / 8;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      partial_q.delete();
      exp_q.delete();
      rd_k = 0;
    end else begin
      automatic bit take_out = (frames_held() > 0) && out_ready;
      automatic bit take_in  = in_valid && (frames_held() < 2);
      if (take_out) begin
        rd_k++;
        if (rd_k == 4) begin
          rd_k = 0;
          for (int i = 0; i < 8; i++) void'(exp_q.pop_front());
        end
      end
      if (take_in) begin
        partial_q.push_back(in_data);
        if (partial_q.size() == 8) begin
          for (int i = 0; i < 8; i++) exp_q.push_back(partial_q[i]);
          partial_q.delete();
        end
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      automatic bit ev = frames_held() > 0;
      check("in_ready", {31'd0, in_ready}, {31'd0, frames_held() < 2});
      check("out_valid", {31'd0, out_valid}, {31'd0, ev});
      if (ev) begin
        check("out_1", {16'd0, out_1}, {16'd0, exp_q[first_idx[rd_k]]});
        check("out_2", {16'd0, out_2}, {16'd0, exp_q[first_idx[rd_k] + 4]});
        check("out_pair", {30'd0, out_pair}, rd_k);
        check("out_last", {31'd0, out_last}, {31'd0, rd_k == 3});
      end else begin
        check("out_last_idle", {31'd0, out_last}, 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  int stall_cnt;

  // Present one sample and hold it until accepted (bounded).
  task automatic push(input logic [W-1:0] d);
    bit acc;
    int n;
    in_valid = 1'b1;
    in_data  = d;
    acc = 0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      if (!acc) stall_cnt++;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      errors++;
      $display("FAIL push_timeout: sample %h never accepted", d);
    end
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic push_frame(input logic [W-1:0] base);
    for (int i = 0; i < 8; i++) push(base + W'(i));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait until the model and DUT both hold no frame (bounded).
  task automatic wait_drained();
    int n;
    n = 0;
    while ((frames_held() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_timeout", n < 100, 32'd1);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    cycles(n);
    rst = 1'b1;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    checks    = 0;
    errors    = 0;
    stall_cnt = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #2;

    // Reset then idle.
    do_reset(3);
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_1", {16'd0, out_1}, 32'h0000);
    check("rst_out_2", {16'd0, out_2}, 32'h0000);
    check("rst_out_pair", {30'd0, out_pair}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    @(posedge clk);
    #1;

    // Single frame, out_ready held high: first pair one cycle after x7.
    out_ready = 1'b1;
    push_frame(16'hA000);
    idle_in();
    @(negedge clk);
    check("sf_valid", {31'd0, out_valid}, 32'd1);
    check("sf_p0_1", {16'd0, out_1}, 32'hA000);
    check("sf_p0_2", {16'd0, out_2}, 32'hA004);
    @(negedge clk);
    check("sf_p1_1", {16'd0, out_1}, 32'hA002);
    check("sf_p1_2", {16'd0, out_2}, 32'hA006);
    @(negedge clk);
    check("sf_p2_1", {16'd0, out_1}, 32'hA001);
    check("sf_p2_2", {16'd0, out_2}, 32'hA005);
    @(negedge clk);
    check("sf_p3_1", {16'd0, out_1}, 32'hA003);
    check("sf_p3_2", {16'd0, out_2}, 32'hA007);
    check("sf_p3_last", {31'd0, out_last}, 32'd1);
    @(negedge clk);
    check("sf_empty", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back frames with continuous input: no input stalls.
    stall_cnt = 0;
    push_frame(16'hA000);
    push_frame(16'hB000);
    idle_in();
    check("b2b_stalls", stall_cnt, 32'd0);
    @(negedge clk);
    check("b2b_b_first", {16'd0, out_1}, 32'hB000);
    @(posedge clk);
    #1;
    wait_drained();

    // Backpressure: two full frames block a third sample until A drains.
    out_ready = 1'b0;
    push_frame(16'hA000);
    push_frame(16'hB000);
    idle_in();
    @(negedge clk);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    fork
      begin
        push(16'hC000);
        for (int i = 1; i < 8; i++) push(16'hC000 + W'(i));
        idle_in();
      end
      begin
        cycles(3);
        out_ready = 1'b1;
      end
    join
    wait_drained();

    // Output stall at pair 1: operands must hold for 5 cycles.
    out_ready = 1'b0;
    push_frame(16'hA000);
    idle_in();
    out_ready = 1'b1;
    cycles(1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_1", {16'd0, out_1}, 32'hA002);
      check("stall_2", {16'd0, out_2}, 32'hA006);
      check("stall_pair", {30'd0, out_pair}, 32'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drained();

    // Mid-frame reset discards the partial A frame.
    for (int i = 0; i < 5; i++) push(16'hA000 + W'(i));
    idle_in();
    do_reset(1);
    @(negedge clk);
    check("mr_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    push_frame(16'hB000);
    idle_in();
    @(negedge clk);
    check("mr_p0_1", {16'd0, out_1}, 32'hB000);
    check("mr_p0_2", {16'd0, out_2}, 32'hB004);
    @(posedge clk);
    #1;
    wait_drained();
    cycles(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_input_reorder.md
Name: fft_input_reorder

Overview:
Front end of the 8-point FFT. Accepts one packed complex sample per beat in natural order, buffers a full 8-sample frame, and emits it as 4 bit-reversed pairs. Each pair drives the in_1/in_2 operands of the stage-1 radix-2 butterflies. Two frame banks in ping-pong let frame k+1 be written while frame k drains, so input sustains 1 sample/cycle.

Parameters:
DATA_W, 16, width of one packed complex sample ([DATA_W-1:DATA_W/2] real, [DATA_W/2-1:0] imaginary, two's complement); passed through unmodified.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
in_valid  in  1  in_data holds a sample
in_ready  out  1  block can accept a sample this cycle
in_data  in  DATA_W  natural-order sample x[n]
out_valid  out  1  out_1/out_2 hold a valid pair
out_ready  in  1  downstream consumes the pair this cycle
out_1  out  DATA_W  first butterfly operand
out_2  out  DATA_W  second butterfly operand
out_pair  out  2  pair index k within frame (0..3)
out_last  out  1  high with pair k=3

Behaviour:
- Reset (rst=0, async):
  - wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0, bank_full=2'b00.
  - All 16 storage words cleared to 0.
  - Outputs: in_ready=1, out_valid=0, out_1=0, out_2=0, out_pair=0, out_last=0.
  - Reset mid-frame discards the partial input frame and any undrained frames. No partial output.
- Write side:
  - in_ready = !bank_full[wr_bank].
  - On in_valid&&in_ready: bank[wr_bank][wr_cnt] <= in_data; wr_cnt++.
  - On the accept with wr_cnt==7: bank_full[wr_bank] <= 1; wr_bank toggles; wr_cnt <= 0.
  - in_data is ignored when in_ready=0.
- Read side:
  - out_valid = bank_full[rd_bank].
  - out_1 = bank[rd_bank][bitrev3(2k)], out_2 = bank[rd_bank][bitrev3(2k+1)], k=rd_cnt.
  - Pair order:
    - k=0: (x0,x4)
    - k=1: (x2,x6)
    - k=2: (x1,x5)
    - k=3: (x3,x7)
  - out_pair=rd_cnt; out_last = out_valid && rd_cnt==3.
  - Outputs are combinational from registered storage/state. They stay stable while out_valid=1 and out_ready=0.
  - On out_valid&&out_ready: rd_cnt++. At rd_cnt==3: bank_full[rd_bank] <= 0; rd_bank toggles; rd_cnt <= 0.
  - When out_valid=0, out_1/out_2 show bank[rd_bank] contents. They are don't-care for checking except right after reset (0).
- Latency: the 8th sample accepted at edge t gives out_valid=1 in the cycle after t (first pair readable after edge t).
- Simultaneous events:
  - Set (write side) and clear (read side) of bank_full in the same cycle always target different banks, and both take effect.
  - Write and read in the same cycle never touch the same bank.
- Full: both banks full gives in_ready=0 until the read side releases the bank on the out_last handshake. in_ready rises the cycle after that handshake.
- Empty: out_valid=0. Read counters hold.
- Wrap-around: wr_cnt 7→0 and rd_cnt 3→0 occur only on handshake. Bank pointers toggle 1→0.
- Throughput: with out_ready=1, 8 in / 4 out per frame, no input stalls.

Decomposition:
- Shared package fft_pkg:
  - FFT_POINTS=8, FFT_LOG2=3, PAIRS=4.
  - Sample type (DATA_W packed complex).
  - Function bitrev3 (3-bit index reversal), shared with later stages' twiddle indexing.
- One sub-module: fft_frame_bank, an 8×DATA_W register file with one write port and two combinational read ports and async active-low clear. Instanced twice, for bank 0 and bank 1.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, release → in_ready=1, out_valid=0, out_1=out_2=16'h0000, out_pair=0.
- Single frame, out_ready=1: x_i=16'hA000+i, i=0..7, one per cycle → 4 consecutive pairs (A000,A004),(A002,A006),(A001,A005),(A003,A007), out_pair 0..3, out_last only on the 4th. First out_valid is one cycle after x7 is accepted.
- Back-to-back frames, continuous in_valid, out_ready=1: frame 2 x_i=16'hB000+i → in_ready never drops, frame-2 pairs (B000,B004)… follow frame 1 with no gap.
- Backpressure: out_ready=0, push 16 samples (A00x, B00x) → in_ready=0 after the 16th. A 17th sample C000 is held off. Raise out_ready → A pairs drain, in_ready=1 one cycle after the A00x out_last handshake, then C000 is accepted and B pairs follow.
- Output stall: hold out_ready=0 for 5 cycles at k=1 → out_1=A002, out_2=A006, out_pair=1 are stable throughout.
- Mid-frame reset: accept A000..A004, assert rst for 1 cycle, then send B000..B007 → outputs are only the B frame pairs, no A data.
